// File: rtl/prefetch_queue.sv
// ============================================================================
// Module      : prefetch_queue
// Description : Instruction-fetch front end. Owns the fetch PC, issues icache
//               reads and buffers up to DEPTH fetched words ahead of decode.
//               Optional macro PREFETCH_BYPASS_EN: zero-latency empty-queue bypass.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module prefetch_queue #(
    parameter int unsigned          DEPTH   = 4,
    parameter int unsigned          WORD_W  = 32,
    parameter logic [WORD_W-1:0]    PC_INIT = '0
) (
    input  logic                         CLK,
    input  logic                         RST,
    output logic                         imemREN,
    output logic [WORD_W-1:0]            imemaddr,
    input  logic                         ihit,
    input  logic [WORD_W-1:0]            imemload,
    input  logic                         redirect,
    input  logic [WORD_W-1:0]            redirect_pc,
    input  logic                         deq,
    output logic                         valid,
    output logic [WORD_W-1:0]            instr,
    output logic [WORD_W-1:0]            pc,
    output logic [WORD_W-1:0]            pc4,
    output logic [$clog2(DEPTH+1)-1:0]   count,
    output logic                         fetch_halted
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = $clog2(DEPTH+1);

    logic [WORD_W-1:0] fpc_q, fpc_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic              halted_q, halted_d;
    logic [WORD_W-1:0] instr_mem_q [DEPTH];
    logic [WORD_W-1:0] pc_mem_q    [DEPTH];

    logic              w_empty, w_req, w_push, w_pop, w_write, w_bypass;
    logic [WORD_W-1:0] w_head_instr, w_head_pc;

    always_comb begin
        w_empty  = (count_q == '0);
        w_req    = !RST && !halted_q && !redirect &&
                   ((count_q < CNT_W'(DEPTH)) || deq);
        w_push   = w_req && ihit;
`ifdef PREFETCH_BYPASS_EN
        w_bypass = w_empty && w_push;
`else
        w_bypass = 1'b0;
`endif
        w_pop    = deq && !w_empty && !redirect;
        // A bypassed word consumed in the same cycle never lands in the queue.
        w_write  = w_push && !(w_bypass && deq);

        fpc_d    = fpc_q;
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        halted_d = halted_q;

        if (w_push) begin
            fpc_d = fpc_q + WORD_W'(4);
            if (imemload[WORD_W-1 -: 6] == 6'b111111)
                halted_d = 1'b1;
        end
        if (w_write)
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        if (w_pop)
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        case ({w_write, w_pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase

        if (redirect) begin
            fpc_d    = redirect_pc & ~WORD_W'(3);
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
            halted_d = 1'b0;
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            fpc_q    <= PC_INIT;
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
            halted_q <= 1'b0;
        end else begin
            fpc_q    <= fpc_d;
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
            halted_q <= halted_d;
        end
    end

    // Storage needs no reset: every read is qualified by count.
    always_ff @(posedge CLK) begin
        if (w_write && !redirect) begin
            instr_mem_q[wr_ptr_q] <= imemload;
            pc_mem_q[wr_ptr_q]    <= fpc_q;
        end
    end

    always_comb begin
        if (w_bypass) begin
            w_head_instr = imemload;
            w_head_pc    = fpc_q;
        end else begin
            w_head_instr = instr_mem_q[rd_ptr_q];
            w_head_pc    = pc_mem_q[rd_ptr_q];
        end
        valid        = !w_empty || w_bypass;
        instr        = valid ? w_head_instr : '0;
        pc           = valid ? w_head_pc : '0;
        pc4          = valid ? (w_head_pc + WORD_W'(4)) : '0;
        imemREN      = w_req;
        imemaddr     = fpc_q;
        count        = count_q;
        fetch_halted = halted_q;
    end

endmodule

`default_nettype wire
